// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : 640x480@60 timing constants and counter types shared with the
//           renderer.
// Revision: 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int CNT_W    = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [CNT_W-1:0] cnt_t;

  // Half-open window test [lo, hi) on unsigned counter values.
  function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// vga_sync_gen_if : timing bundle from the sync generator to the renderer.
// Revision: 1.0 - initial release
// ============================================================================
interface vga_sync_gen_if;
  import vga_pkg::*;

  logic hsync;
  logic vsync;
  logic video_on;
  cnt_t pixel_x;
  cnt_t pixel_y;
  logic line_start;
  logic frame_start;

  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/vga_sync_gen_rise_edge_det.sv
`default_nettype none
// ============================================================================
// rise_edge_det : one-clk pulse on each rising edge of a clk-synchronous input.
// Revision: 1.0 - initial release
// ============================================================================
module rise_edge_det (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_sig,
  output logic      o_pulse
);

  logic r_sig_d;

  // Delay flop resets high so a level already high at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_d <= 1'b1;
    end else begin
      r_sig_d <= i_sig;
    end
  end

  assign o_pulse = i_sig & ~r_sig_d;

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// vga_sync_gen : VGA timing generator; counters advance on each vga_clk rise,
//                outputs registered from the next-state counter values.
// Revision: 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int SYNC_NEG = 1
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       vga_clk,
  vga_sync_gen_if.master  vga
);
  import vga_pkg::*;

  localparam cnt_t c_H_LAST     = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t c_V_LAST     = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t c_H_ACT      = cnt_t'(H_ACTIVE);
  localparam cnt_t c_V_ACT      = cnt_t'(V_ACTIVE);
  localparam cnt_t c_HS_START   = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t c_HS_END     = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t c_VS_START   = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t c_VS_END     = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic c_SYNC_ON    = (SYNC_NEG != 0) ? 1'b0 : 1'b1;

  logic w_pix_stb;
  logic w_h_wrap;
  logic w_v_wrap;
  cnt_t w_h_nxt;
  cnt_t w_v_nxt;

  cnt_t r_h_cnt;
  cnt_t r_v_cnt;
  logic r_hsync;
  logic r_vsync;
  logic r_video_on;
  logic r_line_start;
  logic r_frame_start;

  rise_edge_det u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sig   (vga_clk),
    .o_pulse (w_pix_stb)
  );

  always_comb begin
    w_h_wrap = (r_h_cnt == c_H_LAST);
    w_v_wrap = w_h_wrap && (r_v_cnt == c_V_LAST);
    w_h_nxt  = w_h_wrap ? '0 : cnt_t'(r_h_cnt + 1'b1);
    w_v_nxt  = r_v_cnt;
    if (w_h_wrap) begin
      w_v_nxt = w_v_wrap ? '0 : cnt_t'(r_v_cnt + 1'b1);
    end
  end

  // Pulses are refreshed every clk so they last exactly one clk; everything
  // else only moves on a strobe, which freezes the outputs when vga_clk stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt       <= c_H_LAST;
      r_v_cnt       <= c_V_LAST;
      r_hsync       <= ~c_SYNC_ON;
      r_vsync       <= ~c_SYNC_ON;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= w_pix_stb & w_h_wrap;
      r_frame_start <= w_pix_stb & w_v_wrap;
      if (w_pix_stb) begin
        r_h_cnt    <= w_h_nxt;
        r_v_cnt    <= w_v_nxt;
        r_hsync    <= in_window(w_h_nxt, c_HS_START, c_HS_END) ? c_SYNC_ON : ~c_SYNC_ON;
        r_vsync    <= in_window(w_v_nxt, c_VS_START, c_VS_END) ? c_SYNC_ON : ~c_SYNC_ON;
        r_video_on <= (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
      end
    end
  end

  assign vga.pixel_x     = r_h_cnt;
  assign vga.pixel_y     = r_v_cnt;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.video_on    = r_video_on;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_sync_gen : scoreboard bench for a default 640x480 instance and a
//                   small-timing active-high-sync instance driven in parallel.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vga_clk = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen_if u_if_d ();
  vga_sync_gen_if u_if_s ();

  vga_sync_gen u_dut_d (
    .clk     (clk),
    .rst_n   (rst_n),
    .vga_clk (vga_clk),
    .vga     (u_if_d)
  );

  vga_sync_gen #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_NEG (0)
  ) u_dut_s (
    .clk     (clk),
    .rst_n   (rst_n),
    .vga_clk (vga_clk),
    .vga     (u_if_s)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       ls;
    logic       fs;
  } exp_t;

  typedef struct packed {
    exp_t d;
    exp_t s;
  } pair_t;

  pair_t q[$];

  int HA[2]  = '{640, 16};
  int HF[2]  = '{16, 4};
  int HS[2]  = '{96, 6};
  int HB[2]  = '{48, 6};
  int VA[2]  = '{480, 8};
  int VF[2]  = '{10, 2};
  int VS[2]  = '{2, 2};
  int VB[2]  = '{33, 3};
  int NEG[2] = '{1, 0};

  int pos[2];
  bit prev_v;
  bit mon_en = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  function automatic int h_total(int k);
    return HA[k] + HF[k] + HS[k] + HB[k];
  endfunction

  function automatic int frame_len(int k);
    return h_total(k) * (VA[k] + VF[k] + VS[k] + VB[k]);
  endfunction

  // Reference: pixel position is a linear index into the frame.
  function automatic exp_t model(int k, int p, bit stb);
    exp_t e;
    int   x;
    int   y;
    bit   hact;
    bit   vact;
    x    = p % h_total(k);
    y    = p / h_total(k);
    hact = (x >= HA[k] + HF[k]) && (x < HA[k] + HF[k] + HS[k]);
    vact = (y >= VA[k] + VF[k]) && (y < VA[k] + VF[k] + VS[k]);
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.hs = (NEG[k] != 0) ? !hact : hact;
    e.vs = (NEG[k] != 0) ? !vact : vact;
    e.vo = (x < HA[k]) && (y < VA[k]);
    e.ls = stb && (x == 0);
    e.fs = stb && (p == 0);
    return e;
  endfunction

  function automatic exp_t actual(int k);
    exp_t a;
    if (k == 0) begin
      a = {u_if_d.pixel_x, u_if_d.pixel_y, u_if_d.hsync, u_if_d.vsync,
           u_if_d.video_on, u_if_d.line_start, u_if_d.frame_start};
    end else begin
      a = {u_if_s.pixel_x, u_if_s.pixel_y, u_if_s.hsync, u_if_s.vsync,
           u_if_s.video_on, u_if_s.line_start, u_if_s.frame_start};
    end
    return a;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b",
               name, $time, act.x, act.y, act.hs, act.vs, act.vo, act.ls, act.fs,
               exp.x, exp.y, exp.hs, exp.vs, exp.vo, exp.ls, exp.fs);
    end
  endtask

  function automatic void reset_model();
    for (int k = 0; k < 2; k++) pos[k] = frame_len(k) - 1;
    prev_v = 1'b1;
  endfunction

  // One clk of stimulus: set vga_clk (and optionally release reset), then
  // queue what both instances must show after the following posedge.
  task automatic drive(input bit v, input bit rel);
    bit    stb;
    pair_t pr;
    @(negedge clk);
    vga_clk = v;
    if (rel) rst_n = 1'b1;
    stb    = v && !prev_v;
    prev_v = v;
    if (stb) begin
      for (int k = 0; k < 2; k++) pos[k] = (pos[k] + 1) % frame_len(k);
    end
    pr.d = model(0, pos[0], stb);
    pr.s = model(1, pos[1], stb);
    q.push_back(pr);
    mon_en = 1'b1;
  endtask

  task automatic strobe_period(input int lo_n, input int hi_n);
    for (int i = 0; i < lo_n; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < hi_n; i++) drive(1'b1, 1'b0);
  endtask

  // Asynchronous reset is applied between clk edges and checked at once.
  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    q.delete();
    rst_n = 1'b0;
    reset_model();
    #1;
    check({tag, "_d"}, actual(0), model(0, pos[0], 1'b0));
    check({tag, "_s"}, actual(1), model(1, pos[1], 1'b0));
    repeat (3) @(negedge clk);
    vga_clk = 1'($urandom_range(0, 1));
  endtask

  initial begin : monitor
    pair_t pr;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard_empty @%0t: got 0 entries, expected >=1", $time);
        end else begin
          pr = q.pop_front();
          check("dut_default", actual(0), pr.d);
          check("dut_small", actual(1), pr.s);
        end
      end
    end
  end

  initial begin : stimulus
    int lo_n;
    int hi_n;
    reset_model();
    repeat (3) @(posedge clk);
    #2;
    check("reset_d", actual(0), model(0, pos[0], 1'b0));
    check("reset_s", actual(1), model(1, pos[1], 1'b0));

    drive(1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6000; i++) begin
        lo_n = $urandom_range(1, 2);
        hi_n = ($urandom_range(0, 49) == 0) ? 20 : $urandom_range(1, 2);
        strobe_period(lo_n, hi_n);
      end
      if (r == 0) begin
        async_reset_check("midframe_reset");
        drive(vga_clk, 1'b1);
        repeat (2) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
      end
    end

    repeat (3) drive(1'b0, 1'b0);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
